mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Word-addressed memory slave answering the calculator controller's read/write request interface; the controller is the initiator.
- Holds operand words and receives result words.
- Registered read data with fixed 1-cycle latency: data for a read issued in cycle N is valid in cycle N+1, the cycle the controller samples r_data.
- Adds collision handling, range checking and activity counters for verification visibility.

Parameters:
- ADDR_W, 5, address width in words (matches calculator_pkg).
- MEM_WORD_SIZE, 64, word width in bits (matches calculator_pkg).
- DEPTH, 24, number of implemented words; must satisfy DEPTH <= 2**ADDR_W.
- CNT_W, 16, width of activity counters.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous, active-low reset.
- write  input  1  write request, single-cycle strobe.
- w_addr  input  ADDR_W  write address.
- w_data  input  MEM_WORD_SIZE  write data.
- read  input  1  read request, single-cycle strobe.
- r_addr  input  ADDR_W  read address.
- r_data  output  MEM_WORD_SIZE  read data, registered.
- r_valid  output  1  high the cycle after an accepted read.
- range_err  output  1  sticky; set on any access with addr >= DEPTH.
- collision  output  1  pulse; same-cycle read and write to the same address.
- rd_count  output  CNT_W  saturating count of reads.
- wr_count  output  CNT_W  saturating count of writes.

Behaviour:
- Reset (rst_i==0 at posedge) clears: r_data=0, r_valid=0, range_err=0, collision=0, rd_count=0, wr_count=0.
- Memory array contents are NOT cleared by reset; contents persist across reset.
- No requests are accepted in a reset cycle.
- Write: when write==1 and w_addr<DEPTH, mem[w_addr]<=w_data at the posedge. wr_count increments, saturating at all-ones.
- Read: when read==1, r_data is updated at the posedge with the addressed word. r_valid=1 for exactly the next cycle. rd_count increments, saturating.
- When read==0: r_data holds its last value and r_valid=0.
- Read and write in the same cycle, different addresses: both are serviced independently.
- Read and write in the same cycle, same address (write-first): r_data takes the new w_data, and collision=1 for one cycle.
- Out of range, write with w_addr>=DEPTH: no array change, wr_count still increments, range_err set.
- Out of range, read with r_addr>=DEPTH: r_data<=0, r_valid=1, rd_count increments, range_err set.
- range_err clears only on reset.
- Counters hold at 2**CNT_W-1; they never wrap.
- Back-to-back reads on consecutive cycles are fully pipelined: one result per cycle, r_valid held high.
- Internal state machine for the r_valid/collision pipeline stage: IDLE (no read last cycle) and RESP (read last cycle).
  - IDLE->RESP on read.
  - RESP->RESP on read.
  - RESP->IDLE on !read.
  - Any state->IDLE on reset.
- A reset asserted while in RESP: r_valid is 0 in the following cycle and the pending read data is discarded.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - Each stored word carries one extra even-parity bit, computed on write.
  - On read, the stored parity is rechecked. Mismatch drives output parity_err=1 for the r_valid cycle.
  - Output parity_err (1 bit, reset 0) exists only when the macro is defined.
  - Input inj_parity (1 bit) flips the stored parity bit of the word written in the same cycle, for test.
- Not defined:
  - No parity storage, no parity_err or inj_parity ports.
  - Array width is exactly MEM_WORD_SIZE.

Test Plan:
- Write 0x0000_0002_0000_0003 to addr 4, then read addr 4 one cycle later -> next cycle r_data=0x0000_0002_0000_0003, r_valid=1; wr_count=1, rd_count=1.
- Same cycle: write 0xAAAA_AAAA_5555_5555 to addr 7 and read addr 7 -> next cycle r_data=0xAAAA_AAAA_5555_5555, collision=1 for one cycle.
- Read addr 30 with DEPTH=24 -> r_data=0, r_valid=1, range_err=1 and held. Write addr 30 -> mem[0..23] unchanged.
- Preload addrs 0..3 and issue reads on 4 consecutive cycles -> r_valid high 4 cycles, data in order, no gaps.
- Write addr 2, drop rst_i for one cycle, then read addr 2 -> data retained; counters restart (rd_count=1, wr_count=0).
- With MEM_PARITY_EN: write addr 5 with inj_parity=1, then read addr 5 -> parity_err=1 with r_valid. A clean word gives parity_err=0.

Source files
------------

// File: rtl/mem_responder.sv
// Word-addressed memory slave with 1-cycle registered reads, collision/range flags and activity counters.
// Optional per-word even parity when MEM_PARITY_EN is defined.
module mem_responder #(
  parameter int ADDR_W        = 5,
  parameter int MEM_WORD_SIZE = 64,
  parameter int DEPTH         = 24,
  parameter int CNT_W         = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [MEM_WORD_SIZE-1:0] w_data,
  input  logic                     read,
  input  logic [ADDR_W-1:0]        r_addr,
  output logic [MEM_WORD_SIZE-1:0] r_data,
  output logic                     r_valid,
  output logic                     range_err,
  output logic                     collision,
  output logic [CNT_W-1:0]         rd_count,
`ifdef MEM_PARITY_EN
  input  logic                     inj_parity,
  output logic                     parity_err,
`endif
  output logic [CNT_W-1:0]         wr_count
);

`ifdef MEM_PARITY_EN
  localparam int STORE_W = MEM_WORD_SIZE + 1;
`else
  localparam int STORE_W = MEM_WORD_SIZE;
`endif

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [STORE_W-1:0]       r_mem [DEPTH];
  logic [MEM_WORD_SIZE-1:0] r_rdata;
  logic                     r_coll;
  logic                     r_range;
  logic [CNT_W-1:0]         r_rd_cnt;
  logic [CNT_W-1:0]         r_wr_cnt;

  logic               w_wr_in_range;
  logic               w_rd_in_range;
  logic               w_same_addr;
  logic [STORE_W-1:0] w_store;
  logic [STORE_W-1:0] w_rd_word;

  assign w_wr_in_range = {1'b0, w_addr} < DEPTH_L;
  assign w_rd_in_range = {1'b0, r_addr} < DEPTH_L;
  assign w_same_addr   = write && read && (w_addr == r_addr);

`ifdef MEM_PARITY_EN
  // Stored bit makes the whole word even; inj_parity corrupts it on purpose.
  assign w_store = {(^w_data) ^ inj_parity, w_data};
`else
  assign w_store = w_data;
`endif

  // Write-first forwarding on a same-address collision.
  always_comb begin
    w_rd_word = '0;
    if (w_rd_in_range) begin
      if (w_same_addr) begin
        w_rd_word = w_store;
      end else begin
        w_rd_word = r_mem[r_addr];
      end
    end
  end

  // Array is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk_i) begin
    if (rst_i && write && w_wr_in_range) begin
      r_mem[w_addr] <= w_store;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (read)  w_state_nxt = RESP;
      RESP: if (!read) w_state_nxt = IDLE;
      default:         w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_rdata  <= '0;
      r_coll   <= 1'b0;
      r_range  <= 1'b0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      r_coll <= w_same_addr;
      if (read) begin
        r_rdata <= w_rd_word[MEM_WORD_SIZE-1:0];
        if (r_rd_cnt != CNT_MAX) r_rd_cnt <= r_rd_cnt + CNT_ONE;
      end
      if (write && (r_wr_cnt != CNT_MAX)) begin
        r_wr_cnt <= r_wr_cnt + CNT_ONE;
      end
      if ((read && !w_rd_in_range) || (write && !w_wr_in_range)) begin
        r_range <= 1'b1;
      end
    end
  end

`ifdef MEM_PARITY_EN
  logic r_par_err;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= read && w_rd_in_range && (^w_rd_word);
    end
  end

  assign parity_err = r_par_err;
`endif

  assign r_data    = r_rdata;
  assign r_valid   = (r_state == RESP);
  assign collision = r_coll;
  assign range_err = r_range;
  assign rd_count  = r_rd_cnt;
  assign wr_count  = r_wr_cnt;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (default build, parity disabled).
module tb_mem_responder;
  localparam int ADDR_W = 5;
  localparam int W      = 64;
  localparam int DEPTH  = 24;
  localparam int CNT_W  = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              write;
  logic [ADDR_W-1:0] w_addr;
  logic [W-1:0]      w_data;
  logic              read;
  logic [ADDR_W-1:0] r_addr;
  logic [W-1:0]      r_data;
  logic              r_valid;
  logic              range_err;
  logic              collision;
  logic [CNT_W-1:0]  rd_count;
  logic [CNT_W-1:0]  wr_count;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0]     model [DEPTH];
  logic [CNT_W-1:0] exp_rd;
  logic [CNT_W-1:0] exp_wr;
  logic [W-1:0]     exp_rdata;

  always #5 clk_i = ~clk_i;

  mem_responder #(
    .ADDR_W(ADDR_W), .MEM_WORD_SIZE(W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .write(write), .w_addr(w_addr), .w_data(w_data),
    .read(read), .r_addr(r_addr), .r_data(r_data), .r_valid(r_valid),
    .range_err(range_err), .collision(collision), .rd_count(rd_count), .wr_count(wr_count)
  );

  // Apply one cycle of requests; outputs are sampled 1 ns after the edge.
  task automatic step(input logic wr, input logic [ADDR_W-1:0] wa, input logic [W-1:0] wd,
                      input logic rd, input logic [ADDR_W-1:0] ra);
    write = wr; w_addr = wa; w_data = wd; read = rd; r_addr = ra;
    if (rst_i) begin
      if (rd) begin
        if (ra >= DEPTH) exp_rdata = '0;
        else if (wr && (wa == ra)) exp_rdata = wd;
        else exp_rdata = model[ra];
        exp_rd = exp_rd + 1'b1;
      end
      if (wr) begin
        if (wa < DEPTH) model[wa] = wd;
        exp_wr = exp_wr + 1'b1;
      end
    end
    @(posedge clk_i);
    #1;
    write = 1'b0; read = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    step(1'b0, '0, '0, 1'b0, '0);
    step(1'b0, '0, '0, 1'b0, '0);
    exp_rd = '0; exp_wr = '0;
    vectors++; if (r_data !== '0) begin miscompares++; $display("FAIL reset_r_data: got %h want 0", r_data); end
    vectors++; if (r_valid !== 1'b0) begin miscompares++; $display("FAIL reset_r_valid: got %b want 0", r_valid); end
    vectors++; if (range_err !== 1'b0) begin miscompares++; $display("FAIL reset_range_err: got %b want 0", range_err); end
    vectors++; if (collision !== 1'b0) begin miscompares++; $display("FAIL reset_collision: got %b want 0", collision); end
    vectors++; if (rd_count !== '0) begin miscompares++; $display("FAIL reset_rd_count: got %0d want 0", rd_count); end
    vectors++; if (wr_count !== '0) begin miscompares++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
    rst_i = 1'b1;
  endtask

  task automatic test_write_read;
    step(1'b1, 5'd4, 64'h0000_0002_0000_0003, 1'b0, '0);
    vectors++; if (r_valid !== 1'b0) begin miscompares++; $display("FAIL wr_only_r_valid: got %b want 0", r_valid); end
    step(1'b0, '0, '0, 1'b1, 5'd4);
    vectors++; if (r_data !== 64'h0000_0002_0000_0003) begin miscompares++; $display("FAIL rd4_data: got %h want 0000000200000003", r_data); end
    vectors++; if (r_valid !== 1'b1) begin miscompares++; $display("FAIL rd4_valid: got %b want 1", r_valid); end
    vectors++; if (wr_count !== 16'd1) begin miscompares++; $display("FAIL rd4_wr_count: got %0d want 1", wr_count); end
    vectors++; if (rd_count !== 16'd1) begin miscompares++; $display("FAIL rd4_rd_count: got %0d want 1", rd_count); end
    vectors++; if (collision !== 1'b0) begin miscompares++; $display("FAIL rd4_collision: got %b want 0", collision); end
    step(1'b0, '0, '0, 1'b0, '0);
    vectors++; if (r_valid !== 1'b0) begin miscompares++; $display("FAIL idle_r_valid: got %b want 0", r_valid); end
    vectors++; if (r_data !== 64'h0000_0002_0000_0003) begin miscompares++; $display("FAIL idle_r_data_hold: got %h want 0000000200000003", r_data); end
  endtask

  task automatic test_collision;
    step(1'b1, 5'd7, 64'hAAAA_AAAA_5555_5555, 1'b1, 5'd7);
    vectors++; if (r_data !== 64'hAAAA_AAAA_5555_5555) begin miscompares++; $display("FAIL coll_data: got %h want aaaaaaaa55555555", r_data); end
    vectors++; if (collision !== 1'b1) begin miscompares++; $display("FAIL coll_pulse: got %b want 1", collision); end
    vectors++; if (r_valid !== 1'b1) begin miscompares++; $display("FAIL coll_valid: got %b want 1", r_valid); end
    step(1'b0, '0, '0, 1'b0, '0);
    vectors++; if (collision !== 1'b0) begin miscompares++; $display("FAIL coll_clear: got %b want 0", collision); end
    vectors++; if (wr_count !== 16'd2) begin miscompares++; $display("FAIL coll_wr_count: got %0d want 2", wr_count); end
    vectors++; if (rd_count !== 16'd2) begin miscompares++; $display("FAIL coll_rd_count: got %0d want 2", rd_count); end
  endtask

  task automatic test_diff_addr;
    step(1'b1, 5'd8, 64'h0123_4567_89AB_CDEF, 1'b1, 5'd4);
    vectors++; if (r_data !== 64'h0000_0002_0000_0003) begin miscompares++; $display("FAIL diff_rd_old: got %h want 0000000200000003", r_data); end
    vectors++; if (collision !== 1'b0) begin miscompares++; $display("FAIL diff_collision: got %b want 0", collision); end
    step(1'b0, '0, '0, 1'b1, 5'd8);
    vectors++; if (r_data !== 64'h0123_4567_89AB_CDEF) begin miscompares++; $display("FAIL diff_rd_new: got %h want 0123456789abcdef", r_data); end
    step(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) step(1'b1, ADDR_W'(i), 64'hB2B0_0000_0000_0000 | W'(i * 17), 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b1, ADDR_W'(i));
      vectors++;
      if (r_valid !== 1'b1 || r_data !== exp_rdata) begin
        miscompares++;
        $display("FAIL b2b_rd%0d: got valid=%b data=%h want valid=1 data=%h", i, r_valid, r_data, exp_rdata);
      end
    end
    vectors++; if (rd_count !== exp_rd) begin miscompares++; $display("FAIL b2b_rd_count: got %0d want %0d", rd_count, exp_rd); end
    step(1'b0, '0, '0, 1'b0, '0);
    vectors++; if (r_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_end_valid: got %b want 0", r_valid); end
  endtask

  task automatic test_range;
    for (int i = 0; i < DEPTH; i++) step(1'b1, ADDR_W'(i), 64'hC0DE_0000_0000_0000 | W'(i), 1'b0, '0);
    vectors++; if (range_err !== 1'b0) begin miscompares++; $display("FAIL range_before: got %b want 0", range_err); end
    step(1'b0, '0, '0, 1'b1, 5'd30);
    vectors++; if (r_data !== '0) begin miscompares++; $display("FAIL range_rd30_data: got %h want 0", r_data); end
    vectors++; if (r_valid !== 1'b1) begin miscompares++; $display("FAIL range_rd30_valid: got %b want 1", r_valid); end
    vectors++; if (range_err !== 1'b1) begin miscompares++; $display("FAIL range_rd30_err: got %b want 1", range_err); end
    step(1'b1, 5'd30, '1, 1'b0, '0);
    step(1'b1, 5'd24, '1, 1'b0, '0);
    step(1'b0, '0, '0, 1'b0, '0);
    vectors++; if (range_err !== 1'b1) begin miscompares++; $display("FAIL range_sticky: got %b want 1", range_err); end
    vectors++; if (wr_count !== exp_wr) begin miscompares++; $display("FAIL range_wr_count: got %0d want %0d", wr_count, exp_wr); end
    step(1'b0, '0, '0, 1'b1, 5'd24);
    vectors++; if (r_data !== '0) begin miscompares++; $display("FAIL range_rd24_data: got %h want 0", r_data); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, '0, 1'b1, ADDR_W'(i));
      vectors++;
      if (r_data !== (64'hC0DE_0000_0000_0000 | W'(i))) begin
        miscompares++;
        $display("FAIL range_mem%0d: got %h want %h", i, r_data, 64'hC0DE_0000_0000_0000 | W'(i));
      end
    end
    vectors++; if (rd_count !== exp_rd) begin miscompares++; $display("FAIL range_rd_count: got %0d want %0d", rd_count, exp_rd); end
    step(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_reset_retain;
    step(1'b1, 5'd2, 64'h1234_5678_9ABC_DEF0, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, 5'd2);
    rst_i = 1'b0;
    step(1'b0, '0, '0, 1'b1, 5'd2);
    exp_rd = '0; exp_wr = '0;
    vectors++; if (r_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resp_valid: got %b want 0", r_valid); end
    vectors++; if (r_data !== '0) begin miscompares++; $display("FAIL rst_resp_data: got %h want 0", r_data); end
    vectors++; if (range_err !== 1'b0) begin miscompares++; $display("FAIL rst_range_clear: got %b want 0", range_err); end
    vectors++; if (rd_count !== '0) begin miscompares++; $display("FAIL rst_rd_count: got %0d want 0", rd_count); end
    rst_i = 1'b1;
    step(1'b0, '0, '0, 1'b1, 5'd2);
    vectors++; if (r_data !== 64'h1234_5678_9ABC_DEF0) begin miscompares++; $display("FAIL retain_data: got %h want 123456789abcdef0", r_data); end
    vectors++; if (r_valid !== 1'b1) begin miscompares++; $display("FAIL retain_valid: got %b want 1", r_valid); end
    vectors++; if (rd_count !== 16'd1) begin miscompares++; $display("FAIL retain_rd_count: got %0d want 1", rd_count); end
    vectors++; if (wr_count !== 16'd0) begin miscompares++; $display("FAIL retain_wr_count: got %0d want 0", wr_count); end
    step(1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    rst_i = 1'b0; write = 1'b0; w_addr = '0; w_data = '0; read = 1'b0; r_addr = '0;
    exp_rd = '0; exp_wr = '0; exp_rdata = '0;
    test_reset();
    test_write_read();
    test_collision();
    test_diff_addr();
    test_back_to_back();
    test_range();
    test_reset_retain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
